dmem_ctrl: RTL

- Parametrised data-memory controller; successor to the fixed 64-bit, 256-word store/RAM/load data memory.
- Sits between the MEM stage and an inferred byte-enable synchronous RAM.
- Uses a valid/ready request and response handshake, so the pipeline can stall on it.
- Supports XLEN 32/64, configurable depth, base address and read latency.
- Detects misaligned, out-of-range and illegal-func3 accesses and reports them as error responses instead of corrupting memory.

---
 rtl/dmem_ctrl_pkg.sv | 37 +++
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_ram.sv | 52 +++++
 rtl/dmem_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes,
// response error codes, controller states and the func3 legality rule.
package dmem_ctrl_pkg;

    // RISC-V load/store funct3 encodings (stores use the same low bits)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_MIS   = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_ILL   = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Stores only have B/H/W/D; loads have no 111. A 32-bit datapath has no
    // doubleword access and no zero-extending word load.
    function automatic logic f_illegal(input logic we, input logic [2:0] f3,
                                       input logic xlen64);
        if (we) begin
            return f3[2] || (!xlen64 && (f3 == F3_D));
        end
        return (f3 == 3'b111) || (!xlen64 && ((f3 == F3_D) || (f3 == F3_WU)));
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [2:0]        req_func3;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic [1:0]        rsp_err_code;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );
endinterface

// File: rtl/dmem_ram.sv
// Inferred byte-enable synchronous RAM, write-first on the read port.
// READ_LAT=2 adds an output register behind the array read register.
module dmem_ram #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [XLEN/8-1:0] i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata
);
    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_rd;

    // Byte-lane writes; the read register takes freshly written lanes first
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            for (int unsigned b = 0; b < NB; b++) begin
                r_rd[b*8 +: 8] <= (i_we && i_be[b]) ? i_wdata[b*8 +: 8]
                                                    : r_mem[i_addr][b*8 +: 8];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [XLEN-1:0] r_rd2;

        // Second read pipeline stage
        always_ff @(posedge clk) begin
            r_rd2 <= r_rd;
        end

        assign o_rdata = r_rd2;
    end else begin : g_lat1
        assign o_rdata = r_rd;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready front end, fault checks, store lane
// packing and load extraction around a dmem_ram instance.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned       XLEN      = 64,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       READ_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned LB   = $clog2(NB);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  LAST = 2'(READ_LAT - 1);

    // Fault classification, highest priority first: illegal, misaligned, range
    function automatic err_code_t f_check(input logic we, input logic [2:0] f3,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] off);
        logic mis;
        logic rng;
        case (f3[1:0])
            2'd1:    mis = addr[0];
            2'd2:    mis = |addr[1:0];
            2'd3:    mis = |addr[2:0];
            default: mis = 1'b0;
        endcase
        rng = (addr < BASE_ADDR) || ((off >> LB) >= ADDR_W'(DEPTH));
        if (f_illegal(we, f3, XLEN == 64)) return ERR_ILL;
        if (mis)                           return ERR_MIS;
        if (rng)                           return ERR_RANGE;
        return ERR_NONE;
    endfunction

    function automatic logic [NB-1:0] f_be(input logic [2:0] f3,
                                           input logic [LB-1:0] bo);
        logic [NB-1:0] m;
        for (int unsigned i = 0; i < NB; i++) begin
            m[i] = (i < (32'd1 << f3[1:0]));
        end
        return m << bo;
    endfunction

    function automatic logic [XLEN-1:0] f_pack(input logic [XLEN-1:0] wdata,
                                               input logic [LB-1:0] bo);
        return wdata << {bo, 3'b000};
    endfunction

    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] word,
                                                  input logic [2:0] f3,
                                                  input logic [LB-1:0] bo);
        logic [XLEN-1:0] sh;
        sh = word >> {bo, 3'b000};
        case (f3)
            F3_B:    return XLEN'($signed(sh[7:0]));
            F3_BU:   return XLEN'(sh[7:0]);
            F3_H:    return XLEN'($signed(sh[15:0]));
            F3_HU:   return XLEN'(sh[15:0]);
            F3_W:    return XLEN'($signed(sh[31:0]));
            F3_WU:   return XLEN'(sh[31:0]);
            default: return sh;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_state_nx;
    logic            w_accept;
    err_code_t       w_err;
    logic [ADDR_W-1:0] w_off;
    logic [AW-1:0]   w_idx;
    logic [LB-1:0]   w_bo;
    logic            w_ram_we;
    logic            w_ram_re;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_ram_wdata;
    logic [XLEN-1:0] w_ram_rdata;
    logic [1:0]      r_wait_cnt;
    logic [2:0]      r_ld_f3;
    logic [LB-1:0]   r_ld_bo;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    err_code_t       r_err_code;

    // BASE_ADDR is word aligned, so the byte offset comes straight from the address
    assign w_off       = bus.req_addr - BASE_ADDR;
    assign w_idx       = w_off[LB +: AW];
    assign w_bo        = bus.req_addr[LB-1:0];
    assign w_err       = f_check(bus.req_we, bus.req_func3, bus.req_addr, w_off);
    assign w_be        = f_be(bus.req_func3, w_bo);
    assign w_ram_wdata = f_pack(bus.req_wdata, w_bo);
    assign w_ram_we    = w_accept && bus.req_we && (w_err == ERR_NONE);
    assign w_ram_re    = w_accept && !bus.req_we && (w_err == ERR_NONE);

    assign bus.rsp_rdata    = r_rdata;
    assign bus.rsp_err      = r_err;
    assign bus.rsp_err_code = r_err_code;

    dmem_ram #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_be    (w_be),
        .i_addr  (w_idx),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, handshake outputs and accept strobe (reset blocks accept)
    always_comb begin
        w_state_nx    = r_state;
        w_accept      = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = !rst;
                    if ((w_err != ERR_NONE) || bus.req_we) begin
                        w_state_nx = S_RESP;
                    end else begin
                        w_state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == LAST) begin
                    w_state_nx = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Latch load context at accept, count RAM latency, capture formatted data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_ld_f3    <= '0;
            r_ld_bo    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
            r_ld_f3    <= bus.req_func3;
            r_ld_bo    <= w_bo;
            r_rdata    <= '0;
            r_err      <= (w_err != ERR_NONE);
            r_err_code <= w_err;
        end else if (r_state == S_WAIT) begin
            if (r_wait_cnt == LAST) begin
                r_rdata <= f_extract(w_ram_rdata, r_ld_f3, r_ld_bo);
            end else begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
        end
    end

endmodule
